// File: rtl/dither_scan_ctrl_pkg.sv
// Shared constants and the Bayer threshold ROM for the dither scan controller slice.
package dither_scan_ctrl_pkg;

    localparam int DITHER_WORD_PX = 4;
    localparam int DITHER_PHASE_W = 3;
    localparam int DITHER_FIFO_W  = DITHER_WORD_PX + 2;

    typedef struct packed {
        logic [DITHER_WORD_PX-1:0] data;
        logic                      eol;
        logic                      eof;
    } dither_out_t;

    // 8x8 ordered-dither index matrix; each row packs column 0 in the top 6 bits.
    function automatic logic [5:0] bayer_cell(input logic [2:0] row, input logic [2:0] col);
        logic [47:0] row_bits;
        case (row)
            3'd0:    row_bits = {6'd0,  6'd32, 6'd8,  6'd40, 6'd2,  6'd34, 6'd10, 6'd42};
            3'd1:    row_bits = {6'd48, 6'd16, 6'd56, 6'd24, 6'd50, 6'd18, 6'd58, 6'd26};
            3'd2:    row_bits = {6'd12, 6'd44, 6'd4,  6'd36, 6'd14, 6'd46, 6'd6,  6'd38};
            3'd3:    row_bits = {6'd60, 6'd28, 6'd52, 6'd20, 6'd62, 6'd30, 6'd54, 6'd22};
            3'd4:    row_bits = {6'd3,  6'd35, 6'd11, 6'd43, 6'd1,  6'd33, 6'd9,  6'd41};
            3'd5:    row_bits = {6'd51, 6'd19, 6'd59, 6'd27, 6'd49, 6'd17, 6'd57, 6'd25};
            3'd6:    row_bits = {6'd15, 6'd47, 6'd7,  6'd39, 6'd13, 6'd45, 6'd5,  6'd37};
            3'd7:    row_bits = {6'd63, 6'd31, 6'd55, 6'd23, 6'd61, 6'd29, 6'd53, 6'd21};
            default: row_bits = 48'd0;
        endcase
        return row_bits[6*(3'd7 - col) +: 6];
    endfunction

endpackage

// File: rtl/bayer_dithering.sv
// One-cycle ordered-dither datapath: four 8-bit pixels in, four 1-bit pixels out.
module bayer_dithering
    import dither_scan_ctrl_pkg::*;
#(
    parameter string COLORMODE = "DES"
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [8*DITHER_WORD_PX-1:0] vin,
    input  logic [2:0]                x_pos,
    input  logic [2:0]                y_pos,
    output logic [DITHER_WORD_PX-1:0] vout
);

    // DES panels advance the matrix column per pixel; other modes share one column per word.
    localparam bit PER_PIXEL_COL = (COLORMODE == "DES");

    logic [DITHER_WORD_PX-1:0] dith_s;

    for (genvar i = 0; i < DITHER_WORD_PX; i++) begin : g_px
        logic [2:0] col_s;
        logic [7:0] thr_s;
        assign col_s = PER_PIXEL_COL ? (x_pos + 3'(i)) : x_pos;
        assign thr_s = {bayer_cell(y_pos, col_s), 2'b10};
        assign dith_s[DITHER_WORD_PX-1-i] = (vin[8*(DITHER_WORD_PX-i)-1 -: 8] > thr_s);
    end

    // Output register giving the datapath its fixed one-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            vout <= '0;
        end else begin
            vout <= dith_s;
        end
    end

endmodule

// File: rtl/dither_out_fifo.sv
// Two-entry register FIFO holding dithered words with their line/frame sideband.
module dither_out_fifo
    import dither_scan_ctrl_pkg::*;
#(
    parameter int W = DITHER_FIFO_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic [1:0]   cnt
);

    logic [W-1:0] mem_r [2];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   cnt_r;

    // Storage, pointers and occupancy; the controller never writes when full.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            cnt_r    <= 2'd0;
        end else begin
            if (wr_en) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({wr_en, pop})
                2'b10:   cnt_r <= cnt_r + 2'd1;
                2'b01:   cnt_r <= cnt_r - 2'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign cnt     = cnt_r;

endmodule

// File: rtl/dither_scan_ctrl.sv
// Scan sequencer around bayer_dithering: coordinates, frame phase, sideband pipeline and output buffering.
module dither_scan_ctrl
    import dither_scan_ctrl_pkg::*;
#(
    parameter int    H_WORDS   = 400,
    parameter int    V_LINES   = 1200,
    parameter string COLORMODE = "DES"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_vsync,
    input  logic        cfg_temporal,
    input  logic [31:0] i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [3:0]  o_data,
    output logic        o_eol,
    output logic        o_eof,
    output logic        o_valid,
    input  logic        i_ready
);

    // Counters are at least 3 bits wide so the low 3 bits always exist for the datapath.
    localparam int XW = ($clog2(H_WORDS) < 3) ? 3 : $clog2(H_WORDS);
    localparam int YW = ($clog2(V_LINES) < 3) ? 3 : $clog2(V_LINES);
    localparam logic [XW-1:0] X_LAST = XW'(H_WORDS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    logic [XW-1:0]             x_r;
    logic [YW-1:0]             y_r;
    logic [DITHER_PHASE_W-1:0] phase_r;
    logic                      s1_v_r;
    logic                      s1_eol_r;
    logic                      s1_eof_r;

    logic [XW-1:0]             x_eff_s;
    logic [YW-1:0]             y_eff_s;
    logic [DITHER_PHASE_W-1:0] phase_eff_s;
    logic                      x_last_s;
    logic                      y_last_s;
    logic                      accept_s;
    logic                      pop_s;
    logic [2:0]                x_pos_s;
    logic [2:0]                y_pos_s;
    logic [3:0]                vout_s;
    logic [1:0]                fifo_cnt_s;
    logic [2:0]                occ_s;
    dither_out_t               fifo_head_s;
    dither_out_t               fifo_wr_s;

    // A frame-start pulse takes effect in its own cycle, so a coincident word opens the new frame.
    always_comb begin
        if (i_vsync) begin
            x_eff_s     = '0;
            y_eff_s     = '0;
            phase_eff_s = phase_r + 3'd1;
        end else begin
            x_eff_s     = x_r;
            y_eff_s     = y_r;
            phase_eff_s = phase_r;
        end
    end

    assign x_last_s = (x_eff_s == X_LAST);
    assign y_last_s = (y_eff_s == Y_LAST);
    assign x_pos_s  = x_eff_s[2:0];
    assign y_pos_s  = y_eff_s[2:0] + (cfg_temporal ? phase_eff_s : 3'd0);

    assign pop_s    = o_valid & i_ready;
    assign occ_s    = {1'b0, fifo_cnt_s} + {2'b00, s1_v_r} - {2'b00, pop_s};
    assign o_ready  = (occ_s <= 3'd1);
    assign accept_s = i_valid & o_ready;

    // Scan position and temporal phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r     <= '0;
            y_r     <= '0;
            phase_r <= '0;
        end else begin
            phase_r <= phase_eff_s;
            if (accept_s) begin
                if (x_last_s) begin
                    x_r <= '0;
                    y_r <= y_last_s ? '0 : (y_eff_s + Y_ONE);
                end else begin
                    x_r <= x_eff_s + X_ONE;
                    y_r <= y_eff_s;
                end
            end else if (i_vsync) begin
                x_r <= '0;
                y_r <= '0;
            end
        end
    end

    // Sideband stage aligned with the datapath output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_r   <= 1'b0;
            s1_eol_r <= 1'b0;
            s1_eof_r <= 1'b0;
        end else begin
            s1_v_r   <= accept_s;
            s1_eol_r <= accept_s & x_last_s;
            s1_eof_r <= accept_s & x_last_s & y_last_s;
        end
    end

    bayer_dithering #(
        .COLORMODE (COLORMODE)
    ) u_dither (
        .clk   (clk),
        .rst   (rst),
        .vin   (i_data),
        .x_pos (x_pos_s),
        .y_pos (y_pos_s),
        .vout  (vout_s)
    );

    assign fifo_wr_s = '{data: vout_s, eol: s1_eol_r, eof: s1_eof_r};

    dither_out_fifo #(
        .W (DITHER_FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s1_v_r),
        .wr_data (fifo_wr_s),
        .pop     (pop_s),
        .rd_data (fifo_head_s),
        .cnt     (fifo_cnt_s)
    );

    assign o_valid = (fifo_cnt_s != 2'd0);
    assign o_data  = fifo_head_s.data;
    assign o_eol   = fifo_head_s.eol;
    assign o_eof   = fifo_head_s.eof;

endmodule

// File: tb/tb_dither_scan_ctrl.sv
// Scoreboard bench for dither_scan_ctrl on a small 4x2-word frame.
module tb_dither_scan_ctrl;

    localparam int H = 4;
    localparam int V = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_vsync;
    logic        cfg_temporal;
    logic [31:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  o_data;
    logic        o_eol;
    logic        o_eof;
    logic        o_valid;
    logic        i_ready;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [5:0]  sb_q [$];
    int          mx, my, mp;
    int          max_inflight;
    bit          saw_stall;
    bit          last_ovalid;
    int          obs_x, obs_y;

    always #5 clk = ~clk;

    dither_scan_ctrl #(
        .H_WORDS   (H),
        .V_LINES   (V),
        .COLORMODE ("DES")
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_vsync      (i_vsync),
        .cfg_temporal (cfg_temporal),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_data       (o_data),
        .o_eol        (o_eol),
        .o_eof        (o_eof),
        .o_valid      (o_valid),
        .i_ready      (i_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Recursive-construction Bayer index: bits interleaved from (row^col) and row, reversed.
    function automatic int bayer_ref(input int row, input int col);
        int xo;
        xo = row ^ col;
        return 32 * (xo & 1) + 16 * (row & 1) + 8 * ((xo >> 1) & 1)
             + 4 * ((row >> 1) & 1) + 2 * ((xo >> 2) & 1) + ((row >> 2) & 1);
    endfunction

    function automatic logic [3:0] dither_ref(input logic [31:0] d, input int xp, input int yp);
        logic [3:0] r;
        int         thr;
        int         pix;
        for (int i = 0; i < 4; i++) begin
            thr      = bayer_ref(yp, (xp + i) % 8) * 4 + 2;
            pix      = int'((d >> (24 - 8 * i)) & 32'hFF);
            r[3 - i] = (pix > thr);
        end
        return r;
    endfunction

    task automatic cycle(input logic v, input logic [31:0] d, input logic vs,
                         input logic rdy, input logic temp);
        int   xe, ye, pe, xp, yp;
        logic eol, eof;
        @(negedge clk);
        i_valid      = v;
        i_data       = d;
        i_vsync      = vs;
        i_ready      = rdy;
        cfg_temporal = temp;
        #1;
        last_ovalid = o_valid;
        if (!o_ready) saw_stall = 1'b1;
        if (o_valid && i_ready) begin
            if (sb_q.size() == 0) check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
            else check_eq("out", {26'd0, o_data, o_eol, o_eof}, {26'd0, sb_q.pop_front()});
        end
        xe = vs ? 0 : mx;
        ye = vs ? 0 : my;
        pe = vs ? (mp + 1) % 8 : mp;
        if (v && o_ready) begin
            xp    = xe % 8;
            yp    = (ye + (temp ? pe : 0)) % 8;
            obs_x = int'(dut.x_pos_s);
            obs_y = int'(dut.y_pos_s);
            check_eq("x_pos", obs_x, xp);
            check_eq("y_pos", obs_y, yp);
            eol = (xe == H - 1);
            eof = eol && (ye == V - 1);
            sb_q.push_back({dither_ref(d, xp, yp), eol, eof});
            if (sb_q.size() > max_inflight) max_inflight = sb_q.size();
            if (eol) begin
                mx = 0;
                my = (ye == V - 1) ? 0 : ye + 1;
            end else begin
                mx = xe + 1;
                my = ye;
            end
        end else if (vs) begin
            mx = 0;
            my = 0;
        end
        mp = pe;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb_q.size() > 0; k++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        check_eq("drain_empty", 32'(sb_q.size()), 32'd0);
        repeat (3) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst     = 1'b1;
        i_valid = 1'b0;
        i_vsync = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rst_o_valid", 32'(o_valid), 32'd0);
        check_eq("rst_o_ready", 32'(o_ready), 32'd1);
        rst = 1'b0;
        sb_q.delete();
        mx = 0;
        my = 0;
        mp = 0;
    endtask

    initial begin
        rst = 1'b1; i_vsync = 1'b0; cfg_temporal = 1'b0;
        i_data = 32'd0; i_valid = 1'b0; i_ready = 1'b1;
        mx = 0; my = 0; mp = 0; max_inflight = 0; saw_stall = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_o_valid", 32'(o_valid), 32'd0);
        check_eq("reset_o_data",  32'(o_data),  32'd0);
        check_eq("reset_o_eol",   32'(o_eol),   32'd0);
        check_eq("reset_o_eof",   32'(o_eof),   32'd0);
        check_eq("reset_o_ready", 32'(o_ready), 32'd1);
        rst = 1'b0;

        // One full frame of mid-grey, with first-word latency
        cycle(1'b1, 32'h80808080, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h80808080, 1'b0, 1'b1, 1'b0);
        check_eq("latency_n1", 32'(last_ovalid), 32'd0);
        cycle(1'b1, 32'h80808080, 1'b0, 1'b1, 1'b0);
        check_eq("latency_n2", 32'(last_ovalid), 32'd1);
        repeat (5) cycle(1'b1, 32'h80808080, 1'b0, 1'b1, 1'b0);
        drain();

        // Saturated white and black at every position
        repeat (8) cycle(1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        repeat (8) cycle(1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0);
        drain();

        // Downstream stall for five cycles under continuous input
        max_inflight = 0;
        saw_stall    = 1'b0;
        repeat (4) cycle(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
        repeat (5) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        repeat (6) cycle(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
        drain();
        check_eq("stall_seen", 32'(saw_stall), 32'd1);
        check_eq("inflight_le3", 32'(max_inflight <= 3), 32'd1);

        // Temporal phase after three frame starts
        repeat (3) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 32'h80808080, 1'b0, 1'b1, 1'b1);
        check_eq("temporal_y3", obs_y, 32'd3);
        cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h80808080, 1'b0, 1'b1, 1'b0);
        check_eq("no_temporal_y0", obs_y, 32'd0);
        drain();

        // Frame start coincident with the second word of a line
        cycle(1'b1, 32'h80808080, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'hC0C0C0C0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h40404040, 1'b1, 1'b1, 1'b0);
        check_eq("vsync_word_x", obs_x, 32'd0);
        check_eq("vsync_word_y", obs_y, 32'd0);
        cycle(1'b1, 32'h80808080, 1'b0, 1'b1, 1'b0);
        check_eq("after_vsync_x", obs_x, 32'd1);
        drain();

        // Reset with two words in flight
        cycle(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        apply_reset();
        cycle(1'b1, 32'h80808080, 1'b0, 1'b1, 1'b1);
        check_eq("post_rst_x", obs_x, 32'd0);
        check_eq("post_rst_y", obs_y, 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dither_scan_ctrl.md
# dither_scan_ctrl

Sequencer for the `bayer_dithering` datapath: accepts 32-bit words (4 × 8-bit pixels) from the upstream pixel stream and generates the per-word `x_pos`/`y_pos` screen coordinates, including an optional per-frame temporal phase. It tracks the datapath's fixed 1-cycle latency with a valid/sideband pipeline and adds backpressure through a 2-entry output buffer. It sits between the frame-buffer reader and the EPD output packer.

## Interface
- `H_WORDS`, 400: words per line (pixels/4), ≥2
- `V_LINES`, 1200: lines per frame, ≥2
- `COLORMODE`, "DES": passed unchanged to `bayer_dithering`
- `clk`  in  1  sole clock
- `rst`  in  1  reset; synchronous, active-high
- `i_vsync`  in  1  frame-start pulse
- `cfg_temporal`  in  1  1 = add frame phase to `y_pos`
- `i_data`  in  32  4 pixels, MSB byte = pixel 0
- `i_valid`  in  1  upstream word valid
- `o_ready`  out  1  upstream accept
- `o_data`  out  4  dithered 1-bit pixels, bit 3 = pixel 0
- `o_eol`  out  1  `o_data` is the last word of a line
- `o_eof`  out  1  `o_data` is the last word of a frame
- `o_valid`  out  1  output valid
- `i_ready`  in  1  downstream accept

## Operation
- Accept = `i_valid & o_ready`. Pop = `o_valid & i_ready`.
- Counters: `x` in 0..H_WORDS-1, `y` in 0..V_LINES-1, `phase` 3 bits.
  - On accept, `x` increments.
  - At `x==H_WORDS-1`: `x` goes to 0 and `y` increments.
  - At `y==V_LINES-1`: `y` wraps to 0.
- Datapath drive, combinational, in the accept cycle:
  - `vin = i_data`
  - `x_pos = x[2:0]`
  - `y_pos = y[2:0] + (cfg_temporal ? phase : 0)`, mod 8
- Sideband for an accepted word:
  - eol = (`x==H_WORDS-1`)
  - eof = eol & (`y==V_LINES-1`)
- Stage s1: registers `s1_v`, `s1_eol`, `s1_eof` on every clock (`s1_v` = accept). They align with the datapath's registered `vout`.
- When `s1_v`, `{vout, s1_eol, s1_eof}` is written into the 2-entry FIFO. The FIFO head drives `o_data`/`o_eol`/`o_eof`, and `o_valid = (cnt != 0)`.
- Backpressure: `o_ready = (cnt + s1_v - pop) <= 1`. This guarantees a FIFO write never finds the FIFO full. Full throughput of 1 word/clk is sustained while `i_ready=1`.
- `i_vsync`:
  - Forces `x=0`, `y=0`.
  - Increments `phase` (wraps 7 to 0).
  - Does not flush words already in s1 or the FIFO.
- `i_vsync` coincident with an accept: the word is the first of the new frame. It uses `x=0`, `y=0` and the incremented `phase`, and the counters become `x=1`, `y=0`.
- Auto wrap at end of frame: no `phase` change.
- `cfg_temporal` is sampled in each accept cycle; it may change at any time.
- Reset state: `x`, `y`, `phase`, `s1_*`, `cnt`, FIFO pointers all 0. Outputs `o_valid=0`, `o_data=0`, `o_eol=0`, `o_eof=0`, `o_ready=1`.
- Reset mid-stream discards all in-flight words; no output follows.

## Timing
- Latency: word accepted at cycle N → `o_valid` at N+2, when the FIFO is empty and `i_ready` is held.
- `o_data`, `o_eol`, `o_eof` are held stable while `o_valid & !i_ready`.
- `o_ready` is combinational from `i_ready` through pop. It is the only comb path from input to output.
- Stall at full: `cnt=2` or (`cnt=1` & `s1_v`) with no pop → `o_ready=0`.
- Simultaneous FIFO write and pop at `cnt=2`: legal, `cnt` stays 2.

## Structure
- Shared constants header: `DITHER_WORD_PX=4`, `DITHER_PHASE_W=3`. Counter widths are derived locally with `$clog2`.
- One sub-module: `dither_out_fifo`, a 2-entry, 6-bit-wide register FIFO with write/pop/cnt.
- The controller instantiates it plus one `bayer_dithering` (COLORMODE passed through).

## Test plan
- Reset, then `H_WORDS=4`, `V_LINES=2`, 8 words of `0x80808080` with `i_ready=1` → 8 outputs at N+2 onward:
  - `o_eol` on outputs 4 and 8, `o_eof` on output 8 only
  - `y_pos` sequence 0,0,0,0,1,1,1,1
- Input `0xFFFFFFFF` → `o_data=4'hF`; input `0x00000000` → `o_data=4'h0`, at every `x`/`y`.
- Continuous input with `i_ready` low for 5 cycles → at most 2 words buffered plus 1 in s1, `o_ready` drops, no loss or duplication, output order preserved.
- `cfg_temporal=1`, pulse `i_vsync` 3 times → the first word of the next frame sees `y_pos=3`; with `cfg_temporal=0` it sees `y_pos=0`.
- `i_vsync` asserted in the same cycle as accepting word 2 of a line → that word gets `x_pos=0`, `y_pos=0` and the next word gets `x_pos=1`; outputs already in flight are still delivered.
- Assert `rst` with 2 words in flight → next cycle `o_valid=0`, `o_ready=1`, and the first post-reset word uses `x=0`, `y=0`, `phase=0`.
